filter_cycle_ctrl: RTL and testbench
====================================

FILTER_CYCLE_CTRL -- requirements
Module: filter_cycle_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYC, default 50_000: clk cycles per 1 ms tick (50 MHz clock).
REQ-002 SHALL have parameter FILL_TIMEOUT_MS, default 60_000: max fill time.
REQ-003 SHALL have parameter SETTLE_MS, default 1_000: settle time after fill.
REQ-004 SHALL have parameter FILTER_MS, default 300_000: pump run time.
REQ-005 SHALL have parameter DRAIN_TIMEOUT_MS, default 60_000: max drain time.
REQ-006 SHALL have port clk  in  1  system clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port low_empty  in  1  debounced low-level sensor; 1 = water below low sensor.
REQ-009 SHALL have port high_empty  in  1  debounced high-level sensor; 1 = water below high sensor.
REQ-010 SHALL have port start  in  1  single-cycle cycle request.
REQ-011 SHALL have port abort  in  1  single-cycle abort request.
REQ-012 SHALL have port clear_fault  in  1  single-cycle fault acknowledge.
REQ-013 SHALL have port valve_in  out  1  fill valve open.
REQ-014 SHALL have port pump_on  out  1  filter pump on.
REQ-015 SHALL have port valve_out  out  1  drain valve open.
REQ-016 SHALL have port busy  out  1  state is FILL, SETTLE, FILTER or DRAIN.
REQ-017 SHALL have port done  out  1  single-cycle pulse on DRAIN completion.
REQ-018 SHALL have port fault  out  1  state is FAULT.
REQ-019 SHALL have port fault_code  out  3  0 none, 1 fill timeout, 2 dry-run, 3 drain timeout, 4 sensor inconsistent.
REQ-020 SHALL have port state  out  3  IDLE=0, FILL=1, SETTLE=2, FILTER=3, DRAIN=4, FAULT=5.

Function
REQ-021 SHALL decode valve_in, pump_on, valve_out, busy and fault from the state register only (Moore): valve_in in FILL only, pump_on in FILTER only, valve_out in DRAIN only; at most one actuator active.
REQ-022 SHALL derive a 1 ms tick from a prescaler counting 0..TICK_CYC-1; tick asserts on terminal count.
REQ-023 SHALL keep a 20-bit ms counter incremented on each tick; prescaler and ms counter both clear on every state transition.
REQ-024 SHALL treat a limit as reached on the tick where the incremented ms count equals the limit; the transition takes effect on the next clk edge.
REQ-025 IDLE: start=1 and abort=0 -> FILL; otherwise stay.
REQ-026 FILL: high_empty=0 -> SETTLE; else FILL_TIMEOUT_MS reached -> FAULT, code 1.
REQ-027 SETTLE: SETTLE_MS reached -> FILTER.
REQ-028 FILTER: low_empty=1 -> FAULT, code 2; else FILTER_MS reached -> DRAIN.
REQ-029 DRAIN: low_empty=1 -> IDLE with done=1 for exactly that one cycle; else DRAIN_TIMEOUT_MS reached -> FAULT, code 3.
REQ-030 In any busy state, low_empty=0 with high_empty=1 is valid; low_empty=1 with high_empty=0 -> FAULT, code 4.
REQ-031 In any busy state, abort=1 -> IDLE with all actuators off, no done pulse.
REQ-032 Priority within one cycle: sensor fault (code 4) > abort > state-specific transition > timeout.
REQ-033 FAULT: holds fault_code; clear_fault=1 -> IDLE with fault_code=0; start and abort ignored.
REQ-034 start while busy or in FAULT, and clear_fault outside FAULT, SHALL be ignored.
REQ-035 fault_code SHALL be 0 in every state except FAULT.

Reset
REQ-036 reset SHALL asynchronously force state=IDLE, prescaler=0, ms counter=0, fault_code=0, done=0; all actuator, busy and fault outputs 0.
REQ-037 reset asserted mid-cycle in any state SHALL close all valves and stop the pump immediately, without waiting for a clk edge.

Verification (TICK_CYC=10, FILL_TIMEOUT_MS=20, SETTLE_MS=3, FILTER_MS=5, DRAIN_TIMEOUT_MS=20)
REQ-038 Nominal: start; high_empty 1->0 after 8 ms -> SETTLE; FILTER after 30 cycles; DRAIN after 50 cycles; low_empty=1 -> one done pulse, IDLE.
REQ-039 Fill timeout: start, high_empty held 1 -> FAULT code 1 at 200 cycles; clear_fault -> IDLE, code 0.
REQ-040 Dry-run: low_empty=1 during FILTER -> FAULT code 2 next edge, pump_on=0.
REQ-041 Sensor conflict in DRAIN (low_empty=1, high_empty=0 same cycle) with abort=1 -> FAULT code 4, no done pulse.
REQ-042 Abort in FILL, start+abort in IDLE, start while busy -> IDLE, stay IDLE, ignored respectively.
REQ-043 Reset asserted mid-FILTER between clk edges -> pump_on=0 immediately, state=IDLE.

Source files
------------

// File: rtl/filter_cycle_ctrl.sv
// Filter cycle controller: fill -> settle -> filter -> drain, with ms-based
// timeouts, sensor plausibility checking, abort and latched fault reporting.
module filter_cycle_ctrl #(
    parameter int unsigned TICK_CYC         = 50_000,
    parameter int unsigned FILL_TIMEOUT_MS  = 60_000,
    parameter int unsigned SETTLE_MS        = 1_000,
    parameter int unsigned FILTER_MS        = 300_000,
    parameter int unsigned DRAIN_TIMEOUT_MS = 60_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       low_empty,
    input  logic       high_empty,
    input  logic       start,
    input  logic       abort,
    input  logic       clear_fault,
    output logic       valve_in,
    output logic       pump_on,
    output logic       valve_out,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] state
);

    localparam int unsigned PrescW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_CYC - 1);
    localparam logic [19:0] FillLim   = 20'(FILL_TIMEOUT_MS);
    localparam logic [19:0] SettleLim = 20'(SETTLE_MS);
    localparam logic [19:0] FilterLim = 20'(FILTER_MS);
    localparam logic [19:0] DrainLim  = 20'(DRAIN_TIMEOUT_MS);

    localparam logic [2:0] CodeNone   = 3'd0;
    localparam logic [2:0] CodeFillTo = 3'd1;
    localparam logic [2:0] CodeDryRun = 3'd2;
    localparam logic [2:0] CodeDrainTo = 3'd3;
    localparam logic [2:0] CodeSensor = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFill   = 3'd1,
        StSettle = 3'd2,
        StFilter = 3'd3,
        StDrain  = 3'd4,
        StFault  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [19:0]       ms_q, ms_d, ms_inc;
    logic [2:0]        code_q, code_d;
    logic              done_q, done_d;
    logic              tick;
    logic              in_busy;
    logic              sensor_bad;

    assign tick       = (presc_q == PrescLast);
    assign ms_inc     = ms_q + 20'd1;
    assign in_busy    = (state_q == StFill) || (state_q == StSettle) ||
                        (state_q == StFilter) || (state_q == StDrain);
    // Water above the high sensor but below the low one is physically impossible.
    assign sensor_bad = low_empty && !high_empty;

    // Next-state, fault code and done pulse selection with fixed priority.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) state_d = StFill;
            end
            StFill: begin
                if (!high_empty) begin
                    state_d = StSettle;
                end else if (tick && (ms_inc == FillLim)) begin
                    state_d = StFault;
                    code_d  = CodeFillTo;
                end
            end
            StSettle: begin
                if (tick && (ms_inc == SettleLim)) state_d = StFilter;
            end
            StFilter: begin
                if (low_empty) begin
                    state_d = StFault;
                    code_d  = CodeDryRun;
                end else if (tick && (ms_inc == FilterLim)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (low_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (tick && (ms_inc == DrainLim)) begin
                    state_d = StFault;
                    code_d  = CodeDrainTo;
                end
            end
            StFault: begin
                if (clear_fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Sensor conflict outranks abort, which outranks everything per-state.
        if (in_busy) begin
            if (sensor_bad) begin
                state_d = StFault;
                code_d  = CodeSensor;
                done_d  = 1'b0;
            end else if (abort) begin
                state_d = StIdle;
                done_d  = 1'b0;
            end
        end
        if (state_d != StFault) code_d = CodeNone;
    end

    // Prescaler and ms counter; both restart on every state change.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (tick) begin
            presc_d = '0;
            ms_d    = ms_inc;
        end else begin
            presc_d = presc_q + PrescW'(1);
        end
    end

    // State and timer registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            ms_q    <= '0;
            code_q  <= CodeNone;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        valve_in   = (state_q == StFill);
        pump_on    = (state_q == StFilter);
        valve_out  = (state_q == StDrain);
        busy       = in_busy;
        fault      = (state_q == StFault);
        done       = done_q;
        fault_code = code_q;
        state      = state_q;
    end

endmodule

// File: tb/tb_filter_cycle_ctrl.sv
// Directed bench for filter_cycle_ctrl with a scoreboard of expected outputs.
module tb_filter_cycle_ctrl;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFill   = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StFilter = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StFault  = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       low_empty, high_empty, start, abort, clear_fault;
    logic       valve_in, pump_on, valve_out, busy, done, fault;
    logic [2:0] fault_code, state;
    logic [11:0] obs;

    int unsigned errors = 0;
    int unsigned checks = 0;

    string       tag_q[$];
    logic [11:0] exp_q[$];

    filter_cycle_ctrl #(
        .TICK_CYC        (10),
        .FILL_TIMEOUT_MS (20),
        .SETTLE_MS       (3),
        .FILTER_MS       (5),
        .DRAIN_TIMEOUT_MS(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .low_empty  (low_empty),
        .high_empty (high_empty),
        .start      (start),
        .abort      (abort),
        .clear_fault(clear_fault),
        .valve_in   (valve_in),
        .pump_on    (pump_on),
        .valve_out  (valve_out),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, fault_code, valve_in, pump_on, valve_out, busy, done, fault};

    // Expected output vector derived from the expected state.
    function automatic logic [11:0] model(input logic [2:0] st, input logic [2:0] code,
                                          input logic dn);
        logic vin, pmp, vout, bsy, flt;
        vin  = (st == StFill);
        pmp  = (st == StFilter);
        vout = (st == StDrain);
        bsy  = (st >= StFill) && (st <= StDrain);
        flt  = (st == StFault);
        return {st, code, vin, pmp, vout, bsy, dn, flt};
    endfunction

    task automatic check_out();
        string       t;
        logic [11:0] e;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // Push the expectation, advance n clock edges, then compare.
    task automatic step_chk(input int n, input string tag, input logic [2:0] st,
                            input logic [2:0] code, input logic dn);
        tag_q.push_back(tag);
        exp_q.push_back(model(st, code, dn));
        repeat (n) @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic go_filter();
        start = 1'b1;
        step_chk(1, "gf_fill", StFill, 3'd0, 1'b0);
        start      = 1'b0;
        low_empty  = 1'b0;
        high_empty = 1'b0;
        step_chk(1, "gf_settle", StSettle, 3'd0, 1'b0);
        step_chk(30, "gf_filter", StFilter, 3'd0, 1'b0);
    endtask

    task automatic pulse_clear(input string tag);
        clear_fault = 1'b1;
        step_chk(1, tag, StIdle, 3'd0, 1'b0);
        clear_fault = 1'b0;
        low_empty   = 1'b1;
        high_empty  = 1'b1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; low_empty = 1'b1; high_empty = 1'b1;
        start = 1'b0; abort = 1'b0; clear_fault = 1'b0;
        #1;
        step_chk(0, "reset_state", StIdle, 3'd0, 1'b0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal cycle
        start = 1'b1;
        step_chk(1, "nom_fill", StFill, 3'd0, 1'b0);
        start = 1'b0;
        step_chk(40, "nom_fill_4ms", StFill, 3'd0, 1'b0);
        low_empty = 1'b0;
        step_chk(39, "nom_fill_8ms", StFill, 3'd0, 1'b0);
        high_empty = 1'b0;
        step_chk(1, "nom_settle", StSettle, 3'd0, 1'b0);
        step_chk(29, "nom_settle_end", StSettle, 3'd0, 1'b0);
        step_chk(1, "nom_filter", StFilter, 3'd0, 1'b0);
        step_chk(49, "nom_filter_end", StFilter, 3'd0, 1'b0);
        step_chk(1, "nom_drain", StDrain, 3'd0, 1'b0);
        high_empty = 1'b1;
        step_chk(5, "nom_draining", StDrain, 3'd0, 1'b0);
        low_empty = 1'b1;
        step_chk(1, "nom_done", StIdle, 3'd0, 1'b1);
        step_chk(1, "nom_done_clr", StIdle, 3'd0, 1'b0);

        // Abort, start+abort, start while busy, stray clear_fault
        start = 1'b1;
        step_chk(1, "ctl_fill", StFill, 3'd0, 1'b0);
        step_chk(1, "ctl_start_busy", StFill, 3'd0, 1'b0);
        start = 1'b0;
        abort = 1'b1;
        step_chk(1, "ctl_abort_fill", StIdle, 3'd0, 1'b0);
        start = 1'b1;
        step_chk(1, "ctl_start_abort", StIdle, 3'd0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        clear_fault = 1'b1;
        step_chk(1, "ctl_clear_idle", StIdle, 3'd0, 1'b0);
        clear_fault = 1'b0;

        // Fill timeout at exactly 200 cycles
        start = 1'b1;
        step_chk(1, "to_fill", StFill, 3'd0, 1'b0);
        start = 1'b0;
        step_chk(199, "to_fill_199", StFill, 3'd0, 1'b0);
        step_chk(1, "to_fault", StFault, 3'd1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        step_chk(1, "to_fault_hold", StFault, 3'd1, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        pulse_clear("to_clear");

        // Dry run during filtering
        go_filter();
        step_chk(10, "dry_filter", StFilter, 3'd0, 1'b0);
        low_empty  = 1'b1;
        high_empty = 1'b1;
        step_chk(1, "dry_fault", StFault, 3'd2, 1'b0);
        pulse_clear("dry_clear");

        // Drain timeout at exactly 200 cycles
        go_filter();
        step_chk(50, "dto_drain", StDrain, 3'd0, 1'b0);
        high_empty = 1'b1;
        step_chk(199, "dto_199", StDrain, 3'd0, 1'b0);
        step_chk(1, "dto_fault", StFault, 3'd3, 1'b0);
        pulse_clear("dto_clear");

        // Sensor conflict beats abort in DRAIN
        go_filter();
        step_chk(50, "cf_drain", StDrain, 3'd0, 1'b0);
        low_empty = 1'b1;
        abort     = 1'b1;
        step_chk(1, "cf_fault", StFault, 3'd4, 1'b0);
        abort      = 1'b0;
        high_empty = 1'b1;
        step_chk(1, "cf_no_done", StFault, 3'd4, 1'b0);
        pulse_clear("cf_clear");

        // Abort beats drain completion: no done pulse
        go_filter();
        step_chk(50, "ab_drain", StDrain, 3'd0, 1'b0);
        low_empty  = 1'b1;
        high_empty = 1'b1;
        abort      = 1'b1;
        step_chk(1, "ab_idle", StIdle, 3'd0, 1'b0);
        abort = 1'b0;
        step_chk(1, "ab_no_done", StIdle, 3'd0, 1'b0);

        // Asynchronous reset in the middle of FILTER
        go_filter();
        step_chk(10, "rst_filter", StFilter, 3'd0, 1'b0);
        #3 reset = 1'b1;
        step_chk(0, "rst_async", StIdle, 3'd0, 1'b0);
        #2 reset = 1'b0;
        low_empty  = 1'b1;
        high_empty = 1'b1;
        step_chk(1, "rst_after", StIdle, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
